recursive_doubling_adder: RTL and testbench

- Parallel-prefix (recursive-doubling) carry-lookahead adder: computes A + B + Cin over WIDTH bits.
- Carry statuses are resolved in ceil(log2(WIDTH+1)) combine levels instead of rippling.
- Result and carry-out are registered once; usable as a single-cycle pipelined arithmetic stage in a datapath.

---
 rtl/rd_adder_pkg.sv | 40 ++++
 rtl/recursive_doubling_adder_prefix_net.sv | 42 ++++
 rtl/recursive_doubling_adder.sv | 62 ++++++
 tb/tb_recursive_doubling_adder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rd_adder_pkg.sv
// Shared definitions for the recursive-doubling adder.
//   rd_status_t        : 2-bit carry status per prefix position (KILL/PROP/GEN)
//   RD_DEFAULT_WIDTH   : default operand width
//   rd_bit_status()    : status of one operand bit pair
//   rd_combine()       : prefix combine operator
//   rd_levels()        : number of combine levels needed for a given width
package rd_adder_pkg;

    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b01,
        GEN  = 2'b10
    } rd_status_t;

    localparam int RD_DEFAULT_WIDTH = 32;

    function automatic rd_status_t rd_bit_status(input logic a_bit, input logic b_bit);
        rd_status_t s;
        if (a_bit & b_bit)
            s = GEN;
        else if (~a_bit & ~b_bit)
            s = KILL;
        else
            s = PROP;
        return s;
    endfunction

    // A propagating upper span defers to whatever the lower span resolved to;
    // a killing or generating upper span decides the carry on its own.
    function automatic rd_status_t rd_combine(input rd_status_t hi, input rd_status_t lo);
        return (hi == PROP) ? lo : hi;
    endfunction

    // WIDTH+1 positions (carry-in plus one per bit) need ceil(log2(WIDTH+1))
    // doubling steps before every span reaches position 0.
    function automatic int rd_levels(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/recursive_doubling_adder_prefix_net.sv
// rd_prefix_net: combinational recursive-doubling carry-status network.
//   a, b         : operands (WIDTH bits)
//   cin          : carry-in, seeds position 0
//   final_status : resolved status for positions 0..WIDTH; position i is the
//                  carry into bit i, position WIDTH is the carry out.
module rd_prefix_net
    import rd_adder_pkg::*;
#(
    parameter int WIDTH = RD_DEFAULT_WIDTH
) (
    input  logic                   cin,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic [WIDTH:0][1:0]    final_status
);

    localparam int LEVELS = rd_levels(WIDTH);

    // lvl[j] holds the statuses entering combine level j; lvl[LEVELS] is final.
    rd_status_t lvl [LEVELS+1][WIDTH+1];

    assign lvl[0][0] = cin ? GEN : KILL;

    for (genvar i = 0; i < WIDTH; i++) begin : g_seed
        assign lvl[0][i+1] = rd_bit_status(a[i], b[i]);
    end

    for (genvar j = 0; j < LEVELS; j++) begin : g_level
        for (genvar p = 0; p <= WIDTH; p++) begin : g_pos
            if (p >= (1 << j)) begin : g_comb
                assign lvl[j+1][p] = rd_combine(lvl[j][p], lvl[j][p - (1 << j)]);
            end else begin : g_pass
                assign lvl[j+1][p] = lvl[j][p];
            end
        end
    end

    for (genvar p = 0; p <= WIDTH; p++) begin : g_out
        assign final_status[p] = lvl[LEVELS][p];
    end

endmodule

// File: rtl/recursive_doubling_adder.sv
// recursive_doubling_adder: A + B + Cin through a parallel-prefix carry network,
// with a single output register stage.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : operands on a/b/cin are meaningful this cycle
//   a, b, cin  : unsigned addends and carry-in
//   sum, cout  : registered (a+b+cin) mod 2^WIDTH and carry out
//   out_valid  : registered in_valid, qualifies sum/cout
module recursive_doubling_adder
    import rd_adder_pkg::*;
#(
    parameter int WIDTH = RD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0][1:0] final_status;
    logic [WIDTH-1:0]    carry;
    logic [WIDTH-1:0]    sum_next;
    logic                cout_next;

    rd_prefix_net #(
        .WIDTH (WIDTH)
    ) u_prefix_net (
        .cin          (cin),
        .a            (a),
        .b            (b),
        .final_status (final_status)
    );

    // After the last level no position is PROP, so GEN alone means carry.
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = (rd_status_t'(final_status[i]) == GEN);
        end
    end

    assign sum_next  = a ^ b ^ carry;
    assign cout_next = (rd_status_t'(final_status[WIDTH]) == GEN);

    // Result registers load every cycle; out_valid tells consumers which to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sum       <= sum_next;
            cout      <= cout_next;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_recursive_doubling_adder.sv
module tb_recursive_doubling_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    recursive_doubling_adder #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                                input logic c, input logic v);
        logic [32:0] exp;
        exp = model(x, y, c);
        chk({tag, "_sum"},   {1'b0, sum},        {1'b0, exp[31:0]});
        chk({tag, "_cout"},  {32'd0, cout},      {32'd0, exp[32]});
        chk({tag, "_valid"}, {32'd0, out_valid}, {32'd0, v});
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic c, input logic v);
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = v;
        @(posedge clk);
        #1;
        check_result(tag, x, y, c, v);
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic        rc, rv;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("reset_sum",   {1'b0, sum},        33'd0);
        chk("reset_cout",  {32'd0, cout},      33'd0);
        chk("reset_valid", {32'd0, out_valid}, 33'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed points with hand-derived expectations.
        step("dir_30001", 32'd10000, 32'd20000, 1'b1, 1'b1);
        chk("dir_30001_lit", {1'b0, sum}, 33'd30001);
        step("dir_45005", 32'd45000, 32'd4, 1'b1, 1'b1);
        chk("dir_45005_lit", {1'b0, sum}, 33'd45005);
        step("dir_1001", 32'd1, 32'd999, 1'b1, 1'b1);
        chk("dir_1001_lit", {1'b0, sum}, 33'd1001);
        step("prop_cin1", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        chk("prop_cin1_lit", {cout, sum}, {1'b1, 32'h0000_0000});
        step("prop_cin0", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        chk("prop_cin0_lit", {cout, sum}, {1'b0, 32'hFFFF_FFFF});
        step("msb_gen", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        chk("msb_gen_lit", {cout, sum}, {1'b1, 32'h0000_0000});
        step("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("all_ones_lit", {cout, sum}, {1'b1, 32'hFFFF_FFFF});
        step("zero_cin", 32'd0, 32'd0, 1'b1, 1'b0);
        chk("zero_cin_lit", {cout, sum}, {1'b0, 32'd1});
        step("alt_prop", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum",   {1'b0, sum},        33'd0);
        chk("async_rst_cout",  {32'd0, cout},      33'd0);
        chk("async_rst_valid", {32'd0, out_valid}, 33'd0);

        @(negedge clk);
        rst_n = 1'b1; a = 32'd5; b = 32'd7; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_result("post_rst", 32'd5, 32'd7, 1'b0, 1'b1);
        chk("post_rst_lit", {1'b0, sum}, 33'd12);

        // Randomised back-to-back traffic.
        for (int n = 0; n < 10000; n++) begin
            rx = $urandom();
            ry = $urandom();
            rc = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            step("rand", rx, ry, rc, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
